// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALT control.
// The PC drives the instruction memory address directly; the memory returns the word combinationally.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] MEM_SIZE = 64'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] pc_adr,
    input  logic [31:0] instruction_in,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam int unsigned PC_W  = 64;
    localparam int unsigned CNT_W = 32;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   target_aligned;
    logic              count_full;

    assign pc_adr         = pc;
    assign pc_plus4       = pc + PC_W'(4);
    assign target_aligned = branch_target & ~PC_W'(3);
    assign count_full     = (fetch_count == {CNT_W{1'b1}});

    // Priority: reset > branch_taken > HALT hold > flush > stall > normal fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= RUN;
            halted            <= 1'b0;
            pc                <= RESET_PC;
            if_id_pc          <= '0;
            if_id_instruction <= '0;
            if_id_valid       <= 1'b0;
            fetch_count       <= '0;
        end else if (branch_taken) begin
            pc                <= target_aligned;
            if_id_pc          <= '0;
            if_id_instruction <= '0;
            if_id_valid       <= 1'b0;
            if (target_aligned >= MEM_SIZE) begin
                state  <= HALT;
                halted <= 1'b1;
            end else begin
                state  <= RUN;
                halted <= 1'b0;
            end
        end else if (state == HALT) begin
            if_id_pc          <= '0;
            if_id_instruction <= '0;
            if_id_valid       <= 1'b0;
        end else if (flush) begin
            if_id_pc          <= '0;
            if_id_instruction <= '0;
            if_id_valid       <= 1'b0;
            if (!stall) begin
                pc <= pc_plus4;
            end
        end else if (!stall) begin
            pc                <= pc_plus4;
            if_id_pc          <= pc;
            if_id_instruction <= instruction_in;
            if_id_valid       <= 1'b1;
            if (!count_full) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
            // The last in-range word is still captured as the PC leaves memory.
            if (pc_plus4 >= MEM_SIZE) begin
                state  <= HALT;
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: per-cycle vectors with hand-derived expectations,
// queued at drive time and compared after the clock edge.
module tb_fetch_stage;

    localparam logic [63:0] TB_RESET_PC = 64'h0;
    localparam int unsigned WATCHDOG_CYCLES = 1000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [63:0] pc_adr;
    logic [31:0] instruction_in;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    fetch_stage #(.RESET_PC(TB_RESET_PC), .MEM_SIZE(64'd64)) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .pc_adr            (pc_adr),
        .instruction_in    (instruction_in),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .halted            (halted),
        .fetch_count       (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word at a byte address; distinct for every word.
    function automatic logic [31:0] mw(input logic [63:0] a);
        return 32'h5A00_0000 + 32'(a);
    endfunction

    always_comb instruction_in = mw(pc_adr);

    typedef struct {
        logic        rst;
        logic        stl;
        logic        fls;
        logic        br;
        logic [63:0] tgt;
        logic [63:0] e_pc;
        logic        e_v;
        logic [63:0] e_ipc;
        logic [31:0] e_ins;
        logic        e_h;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   done  = 1'b0;

    task automatic add(input logic r, input logic s, input logic f, input logic b,
                       input logic [63:0] t, input logic [63:0] pc, input logic v,
                       input logic [63:0] ipc, input logic h, input logic [31:0] cnt);
        vec_t x;
        x.rst = r; x.stl = s; x.fls = f; x.br = b; x.tgt = t;
        x.e_pc = pc; x.e_v = v; x.e_ipc = ipc;
        x.e_ins = v ? mw(ipc) : 32'h0;
        x.e_h = h; x.e_cnt = cnt;
        vecs.push_back(x);
    endtask

    // Reset-state check against the fixed post-reset values.
    task automatic check_reset(input int idx);
        if (pc_adr !== TB_RESET_PC || if_id_pc !== 64'h0 || if_id_instruction !== 32'h0 ||
            if_id_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 32'h0) begin
            n_bad++;
            $display("FAIL reset-state vec%0d: pc=%h ipc=%h ins=%h v=%b h=%b cnt=%0d",
                     idx, pc_adr, if_id_pc, if_id_instruction, if_id_valid, halted, fetch_count);
        end
    endtask

    // Watchdog: fail if the vector run does not complete in time.
    initial begin
        repeat (WATCHDOG_CYCLES) @(posedge clk);
        if (!done) begin
            $display("FAIL: watchdog expired after %0d cycles", WATCHDOG_CYCLES);
            $finish;
        end
    end

    initial begin
        vec_t e;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;

        //  rst s f b  tgt       pc      v ipc    h cnt
        add(1, 0,0,0, 64'h0,   64'd0,  0, 64'd0,  0, 0);   // reset
        add(0, 0,0,0, 64'h0,   64'd4,  1, 64'd0,  0, 1);
        add(0, 0,0,0, 64'h0,   64'd8,  1, 64'd4,  0, 2);
        add(0, 1,0,0, 64'h0,   64'd8,  1, 64'd4,  0, 2);   // stall x2 at pc 8
        add(0, 1,0,0, 64'h0,   64'd8,  1, 64'd4,  0, 2);
        add(0, 0,0,0, 64'h0,   64'd12, 1, 64'd8,  0, 3);
        add(0, 1,1,1, 64'h22,  64'h20, 0, 64'd0,  0, 3);   // branch beats stall/flush
        add(0, 0,0,0, 64'h0,   64'h24, 1, 64'h20, 0, 4);
        add(0, 0,0,0, 64'h0,   64'h28, 1, 64'h24, 0, 5);
        add(0, 0,0,1, 64'h10,  64'd16, 0, 64'd0,  0, 5);
        add(0, 1,1,0, 64'h0,   64'd16, 0, 64'd0,  0, 5);   // flush+stall holds pc
        add(0, 0,1,0, 64'h0,   64'd20, 0, 64'd0,  0, 5);   // flush alone advances pc
        add(0, 0,0,0, 64'h0,   64'd24, 1, 64'd20, 0, 6);
        add(0, 0,0,1, 64'h34,  64'd52, 0, 64'd0,  0, 6);
        add(0, 0,0,0, 64'h0,   64'd56, 1, 64'd52, 0, 7);
        add(0, 0,0,0, 64'h0,   64'd60, 1, 64'd56, 0, 8);
        add(0, 0,0,0, 64'h0,   64'd64, 1, 64'd60, 1, 9);   // last word captured, HALT
        add(0, 1,1,0, 64'h0,   64'd64, 0, 64'd0,  1, 9);   // first HALT cycle -> bubble
        for (int i = 0; i < 5; i++)
            add(0, 0,0,0, 64'h0, 64'd64, 0, 64'd0, 1, 9);
        add(0, 0,0,1, 64'h100, 64'h100,0, 64'd0,  1, 9);   // out-of-range branch stays HALT
        add(0, 0,0,1, 64'hB,   64'd8,  0, 64'd0,  0, 9);   // in-range branch resumes RUN
        add(0, 0,0,0, 64'h0,   64'd12, 1, 64'd8,  0, 10);
        add(1, 1,1,1, 64'h30,  64'd0,  0, 64'd0,  0, 0);   // mid-run reset wins
        add(0, 0,0,0, 64'h0,   64'd4,  1, 64'd0,  0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; stall = vecs[i].stl; flush = vecs[i].fls;
            branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if (pc_adr !== e.e_pc || if_id_valid !== e.e_v || if_id_pc !== e.e_ipc ||
                if_id_instruction !== e.e_ins || halted !== e.e_h || fetch_count !== e.e_cnt) begin
                n_bad++;
                $display("FAIL vec%0d: got pc=%h v=%b ipc=%h ins=%h h=%b cnt=%0d want pc=%h v=%b ipc=%h ins=%h h=%b cnt=%0d",
                         i, pc_adr, if_id_valid, if_id_pc, if_id_instruction, halted, fetch_count,
                         e.e_pc, e.e_v, e.e_ipc, e.e_ins, e.e_h, e.e_cnt);
            end
            if (e.rst) begin
                check_reset(i);
            end
        end

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, byte address loaded into the PC on reset.
REQ-002 Parameter MEM_SIZE, default 64, instruction memory size in bytes; fetch addresses at or above it are out of range.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold the PC and the IF/ID register this cycle.
REQ-006 flush  input  1  replace the IF/ID contents with a bubble this cycle.
REQ-007 branch_taken  input  1  redirect the PC to branch_target this cycle.
REQ-008 branch_target  input  64  redirect byte address; bits [1:0] ignored (treated as 0).
REQ-009 pc_adr  output  64  current PC; drives the instruction memory adr input.
REQ-010 instruction_in  input  32  combinational instruction word returned by the memory for pc_adr.
REQ-011 if_id_pc  output  64  PC of the instruction held in IF/ID.
REQ-012 if_id_instruction  output  32  instruction held in IF/ID.
REQ-013 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-014 halted  output  1  fetch is in HALT state.
REQ-015 fetch_count  output  32  number of instructions captured into IF/ID since reset, saturating at 32'hFFFFFFFF.

Function
REQ-016 All outputs are registered except pc_adr, which equals the PC register directly.
REQ-017 States: RUN and HALT; reset enters RUN.
REQ-018 Priority per cycle: reset > branch_taken > flush > stall > normal fetch.
REQ-019 Normal fetch (RUN, no control asserted): IF/ID <= {pc_adr, instruction_in, valid=1}; PC <= PC + 4; fetch_count increments.
REQ-020 Latency: the word at address A appears on if_id_instruction one cycle after pc_adr = A.
REQ-021 stall (RUN): PC, IF/ID and fetch_count hold their values.
REQ-022 flush without branch_taken: if_id_valid <= 0, if_id_pc <= 0, if_id_instruction <= 0; PC advances by 4 unless stall is also high, in which case PC holds.
REQ-023 branch_taken: PC <= {branch_target[63:2], 2'b00}; IF/ID becomes a bubble; stall and flush are ignored that cycle.
REQ-024 Arithmetic is 64-bit unsigned; PC + 4 wraps modulo 2^64 with no flag.
REQ-025 RUN -> HALT: on a normal fetch where PC + 4 >= MEM_SIZE; the word at PC is still captured that cycle, and PC <= PC + 4.
REQ-026 RUN -> HALT: on branch_taken with aligned target >= MEM_SIZE; PC <= that target; IF/ID becomes a bubble.
REQ-027 In HALT: PC holds; IF/ID becomes a bubble on the first HALT cycle and stays a bubble; fetch_count holds; stall and flush have no effect.
REQ-028 halted is high exactly while the state is HALT.
REQ-029 HALT -> RUN: only on branch_taken with aligned target < MEM_SIZE; PC <= target; IF/ID remains a bubble that cycle.
REQ-030 fetch_count increments only when a valid instruction is captured; it never wraps.

Reset
REQ-031 With reset high at a rising edge: PC <= RESET_PC; if_id_pc <= 0; if_id_instruction <= 0; if_id_valid <= 0; fetch_count <= 0; state <= RUN; halted <= 0.
REQ-032 Reset mid-operation (any state, any other inputs) takes effect on that edge and discards all in-flight state.
REQ-033 Fetching resumes on the first edge after reset deasserts, capturing the word at RESET_PC.

Verification
REQ-034 Reset, then 3 free-running cycles with memory words W0..W2 -> pc_adr 0,4,8,12; IF/ID = (0,W0),(4,W1),(8,W2) valid; fetch_count = 3.
REQ-035 stall high for 2 cycles at pc_adr = 8 -> pc_adr stays 8, IF/ID holds (4,W1), fetch_count unchanged; release -> (8,W2) is captured next.
REQ-036 branch_taken with target 0x22 and stall = flush = 1 at pc_adr = 12 -> pc_adr = 0x20 next, if_id_valid = 0; the following cycle captures (0x20, word at 0x20).
REQ-037 MEM_SIZE = 64, free run to pc_adr = 60 -> (60,W15) is captured, halted = 1, pc_adr = 64; one cycle later if_id_valid = 0; values hold for 5 further cycles.
REQ-038 In HALT, branch_taken with target 0x100 -> remains HALT, pc_adr = 0x100; then branch_taken with target 0x8 -> RUN, pc_adr = 8, next capture is (8,W2).
REQ-039 flush and stall together at pc_adr = 16 -> bubble in IF/ID, pc_adr stays 16; reset asserted mid-run -> all REQ-031 values on the next edge.
